// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and defaults for the instruction fetch stage
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry (inst, pc) holding slot for responses IF/ID cannot take
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        full,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    // clear beats push beats pop; a push in the same cycle as a pop refills the slot
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            inst <= in_inst;
            pc   <= in_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, imem handshake and IF/ID register; FETCH_PERF_CNT_EN adds stall/bubble counters
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
`endif
    input  logic        if_we,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    state_e      state;
    logic [31:0] pc;
    logic [31:0] hold_addr;
    logic [31:0] target;
    logic        accept;
    logic        push;
    logic        pop;
    logic        skid_full;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic        bubble_load;
    ifid_t       id_q;
    ifid_t       id_d;
    ifid_t       bubble;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign imem_req  = !rst && (state == DRAIN || !skid_full);
    assign imem_addr = (state == DRAIN) ? hold_addr : pc;
    assign accept    = state == FETCH && imem_req && imem_ack && !flush;
    assign push      = accept && (!if_we || skid_full);
    assign pop       = !flush && if_we && skid_full;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .push    (push),
        .pop     (pop),
        .in_inst (imem_rdata),
        .in_pc   (pc),
        .full    (skid_full),
        .inst    (skid_inst),
        .pc      (skid_pc)
    );

    // pc advances on accepted responses; a flush with an unacked request parks the old address in DRAIN
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            hold_addr <= '0;
        end else if (state == DRAIN) begin
            if (flush) pc <= target;
            if (imem_ack) state <= FETCH;
        end else if (flush) begin
            pc <= target;
            if (imem_req && !imem_ack) begin
                state     <= DRAIN;
                hold_addr <= pc;
            end
        end else if (accept) begin
            pc <= pc + 32'd4;
        end
    end

    // next IF/ID: flush bubble, stall hold, skid first, then fresh response, else bubble
    always_comb begin
        bubble      = '{valid: 1'b0, inst: NOP_INST, pc: id_q.pc, pc4: id_q.pc4};
        bubble_load = flush || (if_we && !skid_full && !accept);
        id_d = flush     ? bubble :
               !if_we    ? id_q :
               skid_full ? '{valid: 1'b1, inst: skid_inst, pc: skid_pc, pc4: skid_pc + 32'd4} :
               accept    ? '{valid: 1'b1, inst: imem_rdata, pc: pc, pc4: pc + 32'd4} :
                           bubble;
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (rst) id_q <= '{valid: 1'b0, inst: NOP_INST, pc: 32'd0, pc4: 32'd4};
        else     id_q <= id_d;
    end

    assign id_valid = id_q.valid;
    assign id_inst  = id_q.inst;
    assign id_pc    = id_q.pc;
    assign id_pc4   = id_q.pc4;

`ifdef FETCH_PERF_CNT_EN
    // saturating counts of stall cycles and bubble loads
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!if_we && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
            if (bubble_load && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, stall/skid, flush and drain behaviour
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_we = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] TAG = 32'h1000_0000;

    assign imem_rdata = imem_addr + TAG;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
`ifdef FETCH_PERF_CNT_EN
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .if_we       (if_we),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic we, input logic fl, input logic ak, input logic [31:0] rp);
        if_we       = we;
        flush       = fl;
        imem_ack    = ak;
        redirect_pc = rp;
        #3;
    endtask

    initial begin
        tick;
        tick;
        set_in(1, 0, 1, 0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'h13);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_pc4", id_pc4, 32'd4);
        tick;
        rst = 1'b0;
        set_in(1, 0, 1, 0);
        chk("a_req", {31'd0, imem_req}, 32'd1);
        chk("a_addr", imem_addr, 32'h0);
        tick;
        set_in(1, 0, 1, 0);
        chk("b_addr", imem_addr, 32'h4);
        chk("b_valid", {31'd0, id_valid}, 32'd1);
        chk("b_pc", id_pc, 32'h0);
        chk("b_pc4", id_pc4, 32'h4);
        chk("b_inst", id_inst, TAG);
        tick;
        set_in(0, 0, 1, 0);
        chk("c_addr", imem_addr, 32'h8);
        chk("c_pc", id_pc, 32'h4);
        tick;
        set_in(0, 0, 1, 0);
        chk("d_req", {31'd0, imem_req}, 32'd0);
        chk("d_pc", id_pc, 32'h4);
        tick;
        set_in(0, 0, 1, 0);
        chk("e_req", {31'd0, imem_req}, 32'd0);
        chk("e_pc", id_pc, 32'h4);
        tick;
        set_in(1, 0, 1, 0);
        chk("f_req", {31'd0, imem_req}, 32'd0);
        chk("f_pc", id_pc, 32'h4);
        tick;
        set_in(1, 0, 1, 0);
        chk("g_pc", id_pc, 32'h8);
        chk("g_inst", id_inst, TAG + 32'h8);
        chk("g_req", {31'd0, imem_req}, 32'd1);
        chk("g_addr", imem_addr, 32'hC);
        tick;
        set_in(1, 1, 1, 32'h100);
        chk("h_pc", id_pc, 32'hC);
        chk("h_addr", imem_addr, 32'h10);
        tick;
        set_in(1, 0, 1, 0);
        chk("i_valid", {31'd0, id_valid}, 32'd0);
        chk("i_inst", id_inst, 32'h13);
        chk("i_addr", imem_addr, 32'h100);
        tick;
        set_in(1, 0, 0, 0);
        chk("j_valid", {31'd0, id_valid}, 32'd1);
        chk("j_pc", id_pc, 32'h100);
        chk("j_addr", imem_addr, 32'h104);
        tick;
        set_in(1, 1, 0, 32'h203);
        chk("k_valid", {31'd0, id_valid}, 32'd0);
        chk("k_addr", imem_addr, 32'h104);
        tick;
        set_in(1, 0, 0, 0);
        chk("l_req", {31'd0, imem_req}, 32'd1);
        chk("l_addr", imem_addr, 32'h104);
        chk("l_valid", {31'd0, id_valid}, 32'd0);
        tick;
        set_in(1, 0, 1, 0);
        chk("m_addr", imem_addr, 32'h104);
        chk("m_valid", {31'd0, id_valid}, 32'd0);
        tick;
        set_in(1, 0, 1, 0);
        chk("n_addr", imem_addr, 32'h200);
        chk("n_valid", {31'd0, id_valid}, 32'd0);
        tick;
        set_in(1, 0, 1, 0);
        chk("o_valid", {31'd0, id_valid}, 32'd1);
        chk("o_pc", id_pc, 32'h200);
        chk("o_pc4", id_pc4, 32'h204);
        chk("o_inst", id_inst, TAG + 32'h200);
        chk("o_addr", imem_addr, 32'h204);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd3);
        chk("bubble_cnt", bubble_cnt, 32'd5);
`endif
        rst = 1'b1;
        tick;
        set_in(1, 0, 1, 0);
        chk("rst2_req", {31'd0, imem_req}, 32'd0);
        chk("rst2_valid", {31'd0, id_valid}, 32'd0);
        chk("rst2_pc", id_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst2_stall", stall_cnt, 32'd0);
        chk("rst2_bubble", bubble_cnt, 32'd0);
`endif
        tick;
        rst = 1'b0;
        set_in(1, 0, 1, 0);
        chk("rst2_addr", imem_addr, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction word presented on IF/ID bubbles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 if_we  input  1  IF/ID write enable from the hazard detector; 0 = stall.
REQ-006 flush  input  1  taken-jump/branch redirect from the jump controller.
REQ-007 redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  word-aligned fetch address.
REQ-010 imem_ack  input  1  request accepted; imem_rdata valid in the same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 id_valid  output  1  IF/ID holds a real instruction.
REQ-013 id_inst  output  32  IF/ID instruction.
REQ-014 id_pc  output  32  IF/ID instruction address.
REQ-015 id_pc4  output  32  id_pc + 4, for jump link writeback.

Function
REQ-016 States: FETCH (normal) and DRAIN (discard one outstanding response); reset enters FETCH.
REQ-017 Once imem_req is high, imem_req and imem_addr SHALL hold stable until the cycle imem_ack is high; zero-wait ack (ack in the first req cycle) allowed.
REQ-018 FETCH: imem_req = 1 when skid buffer empty, 0 when full; imem_addr = pc.
REQ-019 Accepted response in FETCH without flush: pc <= pc + 4 (wraps modulo 2^32).
REQ-020 One-entry skid buffer (inst, pc): captures an accepted response when if_we = 0, or when if_we = 1 but the skid is already full.
REQ-021 if_we = 1, no flush: IF/ID loads skid if full (skid then refills from a same-cycle response or empties), else accepted response, else bubble (id_valid 0, id_inst NOP_INST).
REQ-022 if_we = 0, no flush: IF/ID, id_pc, id_pc4 hold unchanged.
REQ-023 flush = 1 (priority over if_we): IF/ID becomes bubble, skid cleared, pc <= redirect_pc, same-cycle response discarded.
REQ-024 flush while a request is pending without ack: enter DRAIN; keep old imem_req/imem_addr until ack; discard that data; return to FETCH next cycle, issuing redirect_pc.
REQ-025 flush during DRAIN: update pc to newest redirect_pc, remain in DRAIN.
REQ-026 Latency: an instruction acked in cycle N with if_we = 1 and skid empty appears in IF/ID at N+1.
REQ-027 No instruction is duplicated or dropped except those discarded by REQ-023/REQ-024.

Reset
REQ-028 rst: pc = RESET_PC, state FETCH, skid empty, id_valid = 0, id_inst = NOP_INST, id_pc = 0, id_pc4 = 4, imem_req = 0 in the reset cycle.
REQ-029 rst mid-transaction abandons the pending request; the memory side SHALL be reset by the same rst.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: add outputs stall_cnt (32) and bubble_cnt (32), counting cycles with if_we = 0 and cycles loading a bubble; both saturate at 32'hFFFF_FFFF and clear on rst.
REQ-031 Macro undefined: those ports and counters do not exist; all other behaviour identical.

Structure
REQ-032 Shared package holds the state enum (FETCH, DRAIN), NOP_INST and RESET_PC defaults, and the IF/ID bundle typedef (valid, inst, pc, pc4).
REQ-033 Skid buffer is a sub-module fetch_skid_buf; PC/state logic and IF/ID register stay in fetch_unit.

Verification
REQ-034 Reset, ack tied 1, if_we 1 -> imem_addr 0,4,8,...; id_pc 0 at cycle 2 with id_valid 1, id_pc4 4.
REQ-035 if_we 0 for 3 cycles after fetching 0x8 -> IF/ID holds pc 0x4, skid holds 0x8, imem_req 0 until release; then 0x8, 0xC in order.
REQ-036 flush with redirect_pc 0x100 and same-cycle ack of 0x10 -> 0x10 discarded, next imem_addr 0x100, id_valid 0 for one cycle.
REQ-037 imem_ack delayed 4 cycles at addr 0x20, flush to 0x200 in cycle 2 -> addr 0x20 held until ack, data dropped, next request 0x200.
REQ-038 redirect_pc 0x0000_0203 -> fetch address 0x0000_0200.
REQ-039 With FETCH_PERF_CNT_EN, 5 stall cycles and 2 flush bubbles -> stall_cnt 5, bubble_cnt >= 2; rst clears both.
